// File: rtl/tl_lane_queue.sv
// Four-lane vehicle queue model that closes the loop around the left-turn traffic light controller.
// Optional build macro TL_CONFLICT_CHK_EN adds a sticky both-streets-non-red error flag.
module tl_lane_queue #(
    parameter int CNT_W   = 4,
    parameter int Q_MAX   = 15,
    parameter int DEP_CYC = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       La,
    input  logic [1:0]       Lb,
    input  logic             arr_a,
    input  logic             arr_al,
    input  logic             arr_b,
    input  logic             arr_bl,
    output logic             Ta,
    output logic             Tal,
    output logic             Tb,
    output logic             Tbl,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_al,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_bl,
    output logic [3:0]       dep,
    output logic [3:0]       ovf,
    output logic             err_conflict
);

    localparam int TMR_W = (DEP_CYC > 1) ? $clog2(DEP_CYC) : 1;

    typedef enum logic [1:0] {
        LT_GREEN  = 2'b00,
        LT_YELLOW = 2'b01,
        LT_RED    = 2'b10,
        LT_LEFT   = 2'b11
    } light_e;

    // Lane index order everywhere: 0=a, 1=al, 2=b, 3=bl.
    logic [3:0]       grant;
    logic [3:0]       arr;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [TMR_W-1:0] tmr_q [4];
    logic [TMR_W-1:0] tmr_d [4];
    logic [3:0]       dep_q, dep_d;
    logic [3:0]       ovf_q, ovf_d;

    assign grant = {Lb == LT_LEFT, Lb == LT_GREEN, La == LT_LEFT, La == LT_GREEN};
    assign arr   = {arr_bl, arr_b, arr_al, arr_a};

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        dep_d = '0;
        ovf_d = ovf_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            tmr_d[i] = '0;
            if (grant[i] && (cnt_q[i] != '0)) begin
                if (tmr_q[i] == TMR_W'(DEP_CYC - 1)) begin
                    dep_d[i] = 1'b1;
                end else begin
                    tmr_d[i] = tmr_q[i] + TMR_W'(1);
                end
            end
            // Departure is judged on the pre-edge count; a coincident arrival cancels it out.
            if (arr[i] && !dep_d[i]) begin
                if (cnt_q[i] == CNT_W'(Q_MAX)) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else if (dep_d[i] && !arr[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all lanes update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
                tmr_q[i] <= '0;
            end
            dep_q <= '0;
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
                tmr_q[i] <= tmr_d[i];
            end
            dep_q <= dep_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_a  = cnt_q[0];
    assign cnt_al = cnt_q[1];
    assign cnt_b  = cnt_q[2];
    assign cnt_bl = cnt_q[3];
    assign Ta     = (cnt_q[0] != '0);
    assign Tal    = (cnt_q[1] != '0);
    assign Tb     = (cnt_q[2] != '0);
    assign Tbl    = (cnt_q[3] != '0);
    assign dep    = dep_q;
    assign ovf    = ovf_q;

`ifdef TL_CONFLICT_CHK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((La != LT_RED) && (Lb != LT_RED)) begin
            if (!err_q) begin
                $display("WARNING tl_lane_queue: conflicting lights La=%b Lb=%b at %0t", La, Lb, $time);
            end
            err_q <= 1'b1;
        end
    end

    assign err_conflict = err_q;
`else
    assign err_conflict = 1'b0;
`endif

endmodule

// File: tb/tb_tl_lane_queue.sv
// Self-checking bench for tl_lane_queue: directed scenarios then random traffic against a lane-level queue model.
// Compile with +define+TL_CONFLICT_CHK_EN to check the optional conflict flag.
module tb_tl_lane_queue;

    localparam int CNT_W   = 4;
    localparam int Q_MAX   = 15;
    localparam int DEP_CYC = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       La, Lb;
    logic             arr_a, arr_al, arr_b, arr_bl;
    logic             Ta, Tal, Tb, Tbl;
    logic [CNT_W-1:0] cnt_a, cnt_al, cnt_b, cnt_bl;
    logic [3:0]       dep, ovf;
    logic             err_conflict;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: queue depth, service cycles accumulated toward the next departure.
    int m_cnt  [4];
    int m_serv [4];
    int m_dep  [4];
    int m_ovf  [4];
    int m_err;

    tl_lane_queue #(.CNT_W(CNT_W), .Q_MAX(Q_MAX), .DEP_CYC(DEP_CYC)) dut (
        .clk(clk), .reset(reset), .La(La), .Lb(Lb),
        .arr_a(arr_a), .arr_al(arr_al), .arr_b(arr_b), .arr_bl(arr_bl),
        .Ta(Ta), .Tal(Tal), .Tb(Tb), .Tbl(Tbl),
        .cnt_a(cnt_a), .cnt_al(cnt_al), .cnt_b(cnt_b), .cnt_bl(cnt_bl),
        .dep(dep), .ovf(ovf), .err_conflict(err_conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_edge(input logic [1:0] la, input logic [1:0] lb,
                                       input logic [3:0] a, input logic rst);
        bit g [4];
        g[0] = (la == 2'b00);
        g[1] = (la == 2'b11);
        g[2] = (lb == 2'b00);
        g[3] = (lb == 2'b11);
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_cnt[i] = 0; m_serv[i] = 0; m_dep[i] = 0; m_ovf[i] = 0;
            end
            m_err = 0;
            return;
        end
        for (int i = 0; i < 4; i++) begin
            int left;
            left = 0;
            if (g[i] && m_cnt[i] > 0) begin
                m_serv[i] = m_serv[i] + 1;
                if (m_serv[i] == DEP_CYC) begin
                    left = 1;
                    m_serv[i] = 0;
                end
            end else begin
                m_serv[i] = 0;
            end
            m_cnt[i] = m_cnt[i] + int'(a[i]) - left;
            if (m_cnt[i] > Q_MAX) begin
                m_cnt[i] = Q_MAX;
                m_ovf[i] = 1;
            end
            m_dep[i] = left;
        end
`ifdef TL_CONFLICT_CHK_EN
        if (la != 2'b10 && lb != 2'b10) m_err = 1;
`endif
    endfunction

    task automatic compare_all();
        int cnts [4];
        int ts   [4];
        cnts = '{int'(cnt_a), int'(cnt_al), int'(cnt_b), int'(cnt_bl)};
        ts   = '{int'(Ta), int'(Tal), int'(Tb), int'(Tbl)};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("cnt[%0d]", i), cnts[i], m_cnt[i]);
            check($sformatf("T[%0d]", i), ts[i], (m_cnt[i] != 0) ? 1 : 0);
            check($sformatf("dep[%0d]", i), int'(dep[i]), m_dep[i]);
            check($sformatf("ovf[%0d]", i), int'(ovf[i]), m_ovf[i]);
        end
        check("err_conflict", int'(err_conflict), m_err);
    endtask

    // One clock: drive inputs, update the model at the edge, check 1 time unit later.
    task automatic cycle(input logic [1:0] la, input logic [1:0] lb,
                         input logic [3:0] a, input logic rst);
        La = la; Lb = lb; reset = rst;
        {arr_bl, arr_b, arr_al, arr_a} = a;
        @(posedge clk);
        model_edge(la, lb, a, rst);
        #1;
        compare_all();
    endtask

    initial begin
        int deps;
        La = 2'b10; Lb = 2'b10; reset = 1'b1;
        {arr_bl, arr_b, arr_al, arr_a} = 4'b0;

        // Reset holds everything clear even with arrivals pulsing.
        repeat (2) cycle(2'b10, 2'b10, 4'hF, 1'b1);
        check("reset_cnt_a", int'(cnt_a), 0);

        // Build three A-straight vehicles, then drain under A green.
        repeat (3) cycle(2'b10, 2'b00, 4'b0001, 1'b0);
        cycle(2'b10, 2'b00, 4'b0000, 1'b0);
        check("build_cnt_a", int'(cnt_a), 3);
        check("build_Ta", int'(Ta), 1);
        deps = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(2'b00, 2'b10, 4'b0000, 1'b0);
            deps += int'(dep[0]);
            if (k == 5) check("drain_cnt_a_at6", int'(cnt_a), 0);
        end
        check("drain_dep_total", deps, 3);
        check("drain_Ta", int'(Ta), 0);

        // Left grant drains only the left lane; yellow drains nothing.
        repeat (2) cycle(2'b10, 2'b10, 4'b0011, 1'b0);
        repeat (6) cycle(2'b11, 2'b10, 4'b0000, 1'b0);
        check("left_cnt_al", int'(cnt_al), 0);
        check("left_cnt_a", int'(cnt_a), 2);
        repeat (4) cycle(2'b01, 2'b10, 4'b0000, 1'b0);
        check("yellow_cnt_a", int'(cnt_a), 2);

        // Arrival on the departure edge keeps the count but still pulses dep.
        cycle(2'b10, 2'b10, 4'b0100, 1'b0);
        cycle(2'b10, 2'b00, 4'b0000, 1'b0);
        cycle(2'b10, 2'b00, 4'b0100, 1'b0);
        check("simul_cnt_b", int'(cnt_b), 1);
        check("simul_dep_b", int'(dep[2]), 1);
        cycle(2'b10, 2'b10, 4'b0000, 1'b0);
        check("simul_dep_b_once", int'(dep[2]), 0);

        // Saturate B-left, drain it, overflow stays sticky until reset.
        repeat (17) cycle(2'b10, 2'b10, 4'b1000, 1'b0);
        check("sat_cnt_bl", int'(cnt_bl), 15);
        check("sat_ovf_bl", int'(ovf[3]), 1);
        repeat (32) cycle(2'b10, 2'b11, 4'b0000, 1'b0);
        check("sat_drained_cnt_bl", int'(cnt_bl), 0);
        check("sat_ovf_sticky", int'(ovf[3]), 1);
        cycle(2'b10, 2'b10, 4'b0000, 1'b1);
        check("sat_ovf_reset", int'(ovf[3]), 0);

        // Conflicting lights for one cycle, then legal lights.
        cycle(2'b00, 2'b11, 4'b0000, 1'b0);
        repeat (3) cycle(2'b10, 2'b00, 4'b0000, 1'b0);
`ifdef TL_CONFLICT_CHK_EN
        check("conflict_held", int'(err_conflict), 1);
`else
        check("conflict_tied", int'(err_conflict), 0);
`endif

        // Random traffic with occasional mid-run resets.
        for (int k = 0; k < 600; k++) begin
            logic [1:0] la, lb;
            logic [3:0] a;
            la = 2'($urandom_range(0, 3));
            lb = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) :
                 ((la == 2'b10) ? 2'($urandom_range(0, 3)) : 2'b10);
            for (int i = 0; i < 4; i++) a[i] = ($urandom_range(0, 2) == 0);
            cycle(la, lb, a, ($urandom_range(0, 99) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tl_lane_queue.md
Name: tl_lane_queue

Overview:
- Intersection traffic model driven by the light outputs of the left-turn traffic light controller.
- Consumes La/Lb and produces the traffic-present sensor inputs Ta/Tb/Tal/Tbl for it.
- Keeps one vehicle queue per lane: A straight, A left, B straight, B left.
- Vehicles arrive on pulses and leave at a fixed rate while their lane is granted. Closes the loop for self-running controller simulations.

Parameters:
- CNT_W, 4, width of each lane queue counter.
- Q_MAX, 15, queue capacity. Must be at most 2^CNT_W-1.
- DEP_CYC, 2, clock cycles per vehicle departure while granted. Must be at least 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- La  input  2  street A light: 00 green, 01 yellow, 10 red, 11 left-turn green.
- Lb  input  2  street B light; same encoding as La.
- arr_a, arr_al, arr_b, arr_bl  input  1 each  one-cycle vehicle arrival pulse per lane.
- Ta, Tal, Tb, Tbl  output  1 each  lane queue non-empty.
- cnt_a, cnt_al, cnt_b, cnt_bl  output  CNT_W each  current queue depth.
- dep  output  4  registered departure pulses, bit order {bl,b,al,a}.
- ovf  output  4  sticky overflow flags, bit order {bl,b,al,a}.
- err_conflict  output  1  sticky illegal-light flag (see Optional Feature).

Behaviour:
- Reset (sampled on clk edge while reset=1):
  - All counts 0, all timers 0.
  - dep, ovf and err_conflict are 0.
  - Ta/Tal/Tb/Tbl are therefore 0.
  - Reset asserted mid-operation discards every queue on that edge.
- Grants (combinational from inputs):
  - gA = (La==00), gAL = (La==11), gB = (Lb==00), gBL = (Lb==11).
  - Yellow (01) and red (10) grant nothing.
- Per-lane timer, range 0..DEP_CYC-1:
  - On each edge where grant=1 and count>0: if timer==DEP_CYC-1, a departure occurs and timer returns to 0; otherwise timer increments.
  - Timer is cleared to 0 on any edge where grant=0 or count==0.
  - The first departure therefore happens on the DEP_CYC-th granted edge.
  - With DEP_CYC=1, one departure per granted cycle.
- Count update per edge, departure evaluated on the pre-edge count:
  - Arrival only: count+1. If count==Q_MAX, count holds and the lane's ovf bit sets (sticky until reset).
  - Departure only: count-1. No underflow is possible because departure requires count>0.
  - Arrival and departure on the same edge: count unchanged, no ovf, dep pulse still issued.
- dep[i] is 1 for exactly the cycle following the edge on which that lane's departure occurred. It is a registered output.
- Ta = (cnt_a!=0), and likewise for the other three lanes. These are combinational from the count registers, so an arrival is visible 1 cycle after its pulse.
- Lanes are fully independent. Simultaneous events on all four lanes are each handled by the rules above.

Optional Feature:
- Macro: TL_CONFLICT_CHK_EN.
- When defined:
  - err_conflict sets on any edge (reset=0) where La!=10 and Lb!=10, i.e. both streets are non-red at once.
  - The flag is sticky and cleared only by reset.
  - A $display warning is issued the first time it sets.
- When not defined: err_conflict is tied to 0 and no checking logic is built.

Test Plan:
- Reset: reset=1 for 2 cycles with arrivals pulsing -> all cnt 0, dep 0, ovf 0, Ta..Tbl 0.
- Queue build and drain, defaults: La=10, Lb=00, 3 arr_a pulses -> cnt_a=3, Ta=1. Then La=00, Lb=10 -> dep[0] pulses every 2 cycles, 3 times in total. cnt_a reaches 0 after 6 granted cycles, then Ta=0.
- Left grant isolation: cnt_a=2 and cnt_al=2, La=11 -> only cnt_al drains to 0. cnt_a stays 2. La=01 (yellow) -> no departures on any lane.
- Simultaneous arrival and departure: cnt_b=1, Lb=00, arr_b pulsed on the departure edge -> cnt_b stays 1, dep[2]=1 for 1 cycle.
- Saturation: 17 arr_bl pulses with Lb=10 -> cnt_bl=15, ovf[3]=1. ovf[3] stays 1 after draining, until reset.
- TL_CONFLICT_CHK_EN: La=00 and Lb=11 for 1 cycle -> err_conflict=1 and held. Without the macro -> err_conflict remains 0.
